// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: requester index and the
// response-tracking tag carried alongside each command.
package memory_arbiter_pkg;

    localparam int MAX_REQ = 4;

    typedef logic [1:0] req_id_t;

    typedef struct packed {
        logic    rd;
        req_id_t id;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: requester ptr has top priority, then ptr+1, ... mod N.
// No grant is issued while reset is high.
module rr_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output req_id_t      gnt_id
);

    req_id_t ptr;

    always_comb begin
        int   idx;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr) + k) % N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_id   = req_id_t'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (gnt_id == req_id_t'(N - 1)) ? '0 : gnt_id + 2'd1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between NUM_REQ requesters: registers the
// winning command onto the mem_* pins and routes 1-cycle read data back.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_wr_en,
    output logic                          mem_rd_en,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    logic [NUM_REQ-1:0]    gnt;
    req_id_t               gnt_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    rsp_tag_t              tag1;
    rsp_tag_t              tag2;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_gnt = gnt;

    // gnt is one-hot, so an OR-style mux over the requester slices suffices
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            tag1      <= '0;
            tag2      <= '0;
        end else begin
            if (|gnt) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_wr_en <= sel_we;
                mem_rd_en <= ~sel_we;
                tag1.rd   <= ~sel_we;
                tag1.id   <= gnt_id;
            end else begin
                mem_wr_en <= 1'b0;
                mem_rd_en <= 1'b0;
                tag1      <= '0;
            end
            tag2 <= tag1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag2.rd && (tag2.id == req_id_t'(i));
        end
    end

    assign rsp_rdata = mem_rdata;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Round-robin arbiter that shares one `memory_design` instance between `NUM_REQ` requesters. Each requester issues single-beat reads or writes through a valid/grant handshake. The arbiter registers the winning command onto the memory's `addr`/`wr_en`/`rd_en`/`wdata` pins and routes the memory's 1-cycle `rdata` back to the requester that issued the read. It sits directly between requester agents and the memory model, and owns all memory-side control.

## Interface
- `ADDR_WIDTH`, 2: memory address width; must match the memory.
- `DATA_WIDTH`, 8: memory data width; must match the memory.
- `NUM_REQ`, 2: number of requesters; legal values are 2..4.
- `clk`  in  1: single clock for the block and the memory.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: bit i = requester i has a command pending.
- `req_we`  in  NUM_REQ: bit i = 1 for write, 0 for read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH: packed; slice i belongs to requester i.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH: packed; slice i belongs to requester i.
- `req_gnt`  out  NUM_REQ: one-hot or zero; command i accepted this cycle.
- `rsp_valid`  out  NUM_REQ: one-hot or zero; read data for requester i this cycle.
- `rsp_rdata`  out  DATA_WIDTH: shared read data; meaningful only while `rsp_valid` ≠ 0.
- `mem_addr`  out  ADDR_WIDTH: to memory `addr`.
- `mem_wr_en`  out  1: to memory `wr_en`.
- `mem_rd_en`  out  1: to memory `rd_en`.
- `mem_wdata`  out  DATA_WIDTH: to memory `wdata`.
- `mem_rdata`  in  DATA_WIDTH: from memory `rdata`.

## Operation
- Handshake:
  - A requester raises `req_valid[i]` and holds `req_we`, `req_addr` and `req_wdata` stable until `req_gnt[i]`.
  - A transfer occurs in a cycle where `req_valid[i] && req_gnt[i]`.
  - The requester may drop `req_valid` or present a new command in the next cycle.
  - Withdrawing `req_valid` before grant is legal; the command is simply not issued.
- Arbitration:
  - Combinational over `req_valid`, using a priority pointer `ptr`.
  - Requester `ptr` has highest priority, then `ptr+1`, … mod `NUM_REQ`.
  - At most one grant per cycle. `req_gnt` = 0 when no valid requests.
- Pointer update: on a grant to requester g, `ptr` becomes `(g+1) mod NUM_REQ`. With no grant, `ptr` holds.
  - Starvation bound: a continuously valid requester is granted within `NUM_REQ` cycles.
- Command stage: on a transfer, the next edge registers:
  - `mem_addr` ← `req_addr[g]`
  - `mem_wdata` ← `req_wdata[g]`
  - `mem_wr_en` ← `req_we[g]`
  - `mem_rd_en` ← `!req_we[g]`
- With no transfer, `mem_wr_en` and `mem_rd_en` register 0, and `mem_addr`/`mem_wdata` hold their values.
- Response tracking:
  - A 2-stage pipeline carries {read flag, requester id} alongside the command.
  - `rsp_valid[id]` asserts when the stage-2 read flag is set.
  - `rsp_rdata` = `mem_rdata`, passed through combinationally.
  - Writes produce no response.
- Ordering: commands reach memory in grant order, so a read granted after a write to the same address returns the new data.
- Reset values: `req_gnt`=0, `rsp_valid`=0, `mem_wr_en`=0, `mem_rd_en`=0, `mem_addr`=0, `mem_wdata`=0, `ptr`=0, pipeline flags=0.

## Timing
- Cycle T: handshake completes (`req_gnt` is combinational from `req_valid` and `ptr`).
- Cycle T+1: command is on the `mem_*` pins; the memory acts on the edge that ends T+1.
- Read data: `rsp_valid[i]` and valid `rsp_rdata` appear in cycle T+2. Read latency is 2 cycles from grant.
- Throughput: one transfer per cycle, sustained; responses return in grant order with no gaps added.
- Back-to-back grants: if requesters A, B and A are granted in T, T+1 and T+2, read responses follow in T+2, T+3 and T+4.
- Reset mid-operation: reset asserted in any cycle clears all in-flight commands and pipeline flags at that edge.
  - No `rsp_valid` for reads granted before reset.
  - A command registered onto `mem_*` in the reset cycle is dropped (enables forced 0).
- `reset` has priority over a simultaneous `req_valid`: no grant is issued while `reset` is high.

## Structure
- Package `memory_arbiter_pkg` holds:
  - `MAX_REQ` = 4.
  - typedef `req_id_t` (2-bit requester index).
  - typedef `rsp_tag_t` struct {read flag, `req_id_t`} for the response pipeline.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs: `clk`, `reset`, `req`.
  - Outputs: one-hot `gnt`, encoded `gnt_id`.
  - Holds the `ptr` register and the masked priority select.
- `memory_arbiter` contains the command register, the tag pipeline and the response routing.

## Test plan
- Post-reset idle: hold `reset` 2 cycles with requests active → no `req_gnt`, all `mem_*` enables 0, `ptr`=0. First grant after release goes to requester 0.
- Write then read from one requester:
  - Requester 0 writes 8'hA5 to addr 2.
  - Requester 0 reads addr 2 in the next cycle.
  - Expect `rsp_valid`=2'b01 with `rsp_rdata`=8'hA5, two cycles after the read grant.
- Contention: both requesters hold `req_valid` for 6 cycles → grants alternate 01, 10, 01, 10, 01, 10; every grant produces a `mem_*` command one cycle later.
- Read routing:
  - Memory preloaded with addr0=8'h11 and addr1=8'h22.
  - Requester 0 reads addr 0; requester 1 reads addr 1, both continuously valid.
  - Expect `rsp_valid`=01 with 8'h11, then `rsp_valid`=10 with 8'h22, in consecutive cycles.
- Reset mid-read:
  - Read granted in cycle T; `reset` asserted in T+1.
  - Expect no `rsp_valid` in T+2 and `mem_rd_en`=0 after that edge.
- NUM_REQ=3 fairness: requesters 0 and 2 continuously valid; requester 1 raises `req_valid` while 0 is being granted → requester 1 is granted within 3 cycles.
